// File: rtl/mdr_mem_ctrl.sv
// Memory-access sequencer for the MAR/MDR path: loads MAR, optionally MDR, and runs a
// req/ack handshake with a bounded wait, reporting done or timeout.
module mdr_mem_ctrl #(
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              write,
  input  logic [31:0]       addr,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              MARin,
  output logic              MDRin,
  output logic              MDR_in,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_req,
  output logic              mem_we,
  input  logic              mem_ack
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StReq, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  // Upper address bits are deliberately dropped.
  logic unused_addr;
  assign unused_addr = ^addr[31:ADDR_W];

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    busy    = 1'b0;
    done    = 1'b0;
    MARin   = 1'b0;
    MDRin   = 1'b0;
    MDR_in  = 1'b0;
    mem_req = 1'b0;
    mem_we  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          addr_d  = addr[ADDR_W-1:0];
          we_d    = write;
          err_d   = 1'b0;
          state_d = StSetup;
        end
      end
      StSetup: begin
        busy    = 1'b1;
        MARin   = 1'b1;
        // Store: MDR takes the store data from BusMuxOut (MDR_in stays 0).
        MDRin   = we_q;
        cnt_d   = '0;
        state_d = StReq;
      end
      StReq: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        mem_we  = we_q;
        // Ack is checked first so it wins over a coincident timeout.
        if (mem_ack) begin
          if (!we_q) begin
            MDRin  = 1'b1;
            MDR_in = 1'b1;
          end
          state_d = StDone;
        end else if (cnt_q == CntLast) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign err      = err_q;
  assign mem_addr = addr_q;

endmodule

// File: tb/tb_mdr_mem_ctrl.sv
// Bench for mdr_mem_ctrl: table of accesses with a scoreboard of expected results,
// plus hand-written reset and stray-ack sequences.
module tb_mdr_mem_ctrl;

  localparam int unsigned AW = 9;
  localparam int unsigned TO = 15;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          write = 1'b0;
  logic [31:0]   addr = '0;
  logic          mem_ack = 1'b0;
  logic          busy, done, err, MARin, MDRin, MDR_in, mem_req, mem_we;
  logic [AW-1:0] mem_addr;

  int checks = 0;
  int errors = 0;

  mdr_mem_ctrl #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .write    (write),
    .addr     (addr),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .MARin    (MARin),
    .MDRin    (MDRin),
    .MDR_in   (MDR_in),
    .mem_addr (mem_addr),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_ack  (mem_ack)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    int          ack_k;       // REQ cycle carrying mem_ack, 0 = never
    logic        ack_early;   // also drive mem_ack in IDLE/SETUP
    logic        glitch;      // extra start pulse in REQ cycle 1
    int          e_addr;
    int          e_err;
    int          e_req;
    int          e_done;      // cycle index of done, start cycle = 0
    int          e_mdrin_setup;
    int          e_mdrin_req;
    int          e_mdr_in;
    int          e_we;
  } vec_t;

  vec_t vecs[6];
  vec_t sb[$];

  function automatic void check(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endfunction

  function automatic int outs();
    return int'({busy, done, err, MARin, MDRin, MDR_in, mem_req, mem_we});
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    vec_t e;
    int marin_n = 0, req_n = 0, we_n = 0, mdrin_req_n = 0, mdr_in_n = 0;
    int mdrin_setup = 0, addr_setup = 0, err_setup = 0, unstable = 0;
    int done_c = -1, err_done = 0;
    logic got = 1'b0;
    sb.push_back(v);
    for (int c = 0; c < 40 && !got; c++) begin
      @(posedge clock); #1;
      start   = (c == 0) || (v.glitch && c == 2);
      write   = (c == 0) ? v.wr : ~v.wr;
      addr    = (c == 0) ? v.addr : $urandom();
      mem_ack = (v.ack_k != 0 && c == 1 + v.ack_k) || (v.ack_early && c <= 1);
      @(negedge clock);
      if (MARin) marin_n++;
      if (MDR_in) mdr_in_n++;
      if (c == 1) begin
        mdrin_setup = int'(MDRin);
        addr_setup  = int'(mem_addr);
        err_setup   = int'(err);
      end
      if (mem_req) begin
        req_n++;
        if (mem_we) we_n++;
        if (MDRin) mdrin_req_n++;
        if (int'(mem_addr) != addr_setup) unstable = 1;
      end
      if (done) begin
        got      = 1'b1;
        done_c   = c;
        err_done = int'(err);
        if (int'(mem_addr) != addr_setup) unstable = 1;
      end
    end
    @(posedge clock); #1;
    start   = 1'b0;
    mem_ack = 1'b0;
    @(negedge clock);
    e = sb.pop_front();
    check($sformatf("v%0d_done_cycle", idx), done_c, e.e_done);
    check($sformatf("v%0d_err_at_done", idx), err_done, e.e_err);
    check($sformatf("v%0d_err_cleared_setup", idx), err_setup, 0);
    check($sformatf("v%0d_mem_addr", idx), addr_setup, e.e_addr);
    check($sformatf("v%0d_addr_stable", idx), unstable, 0);
    check($sformatf("v%0d_marin_cycles", idx), marin_n, 1);
    check($sformatf("v%0d_req_cycles", idx), req_n, e.e_req);
    check($sformatf("v%0d_we_cycles", idx), we_n, e.e_we);
    check($sformatf("v%0d_mdrin_setup", idx), mdrin_setup, e.e_mdrin_setup);
    check($sformatf("v%0d_mdrin_req", idx), mdrin_req_n, e.e_mdrin_req);
    check($sformatf("v%0d_mdr_in", idx), mdr_in_n, e.e_mdr_in);
    check($sformatf("v%0d_idle_busy", idx), int'(busy), 0);
    check($sformatf("v%0d_err_held", idx), int'(err), e.e_err);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int done_seen;
    //            wr    addr           ack ae  gl  addr   err req done ms mr mi we
    vecs[0] = '{1'b0, 32'h0000_0123,  1, 1'b0, 1'b0, 'h123, 0,  1,  3, 0, 1, 1,  0};
    vecs[1] = '{1'b1, 32'hFFFF_FE05,  4, 1'b1, 1'b0, 'h005, 0,  4,  6, 1, 0, 0,  4};
    vecs[2] = '{1'b0, 32'h0000_00AA,  0, 1'b0, 1'b0, 'h0AA, 1, 15, 17, 0, 0, 0,  0};
    vecs[3] = '{1'b0, 32'h0000_03FF, 15, 1'b0, 1'b1, 'h1FF, 0, 15, 17, 0, 1, 1,  0};
    vecs[4] = '{1'b1, 32'h0000_01FE,  0, 1'b0, 1'b0, 'h1FE, 1, 15, 17, 1, 0, 0, 15};
    vecs[5] = '{1'b1, 32'h0000_0100,  1, 1'b0, 1'b1, 'h100, 0,  1,  3, 1, 0, 0,  1};

    reset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_outs", outs(), 0);
    check("reset_mem_addr", int'(mem_addr), 0);
    reset = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Stray ack while idle: no strobes, no state change.
    for (int c = 0; c < 3; c++) begin
      @(posedge clock); #1;
      mem_ack = 1'b1;
      @(negedge clock);
      check($sformatf("idle_ack_outs_%0d", c), outs() & 'hFB, 0);
    end
    @(posedge clock); #1;
    mem_ack = 1'b0;

    // Reset held 2 edges mid-REQ with ack high aborts without done.
    done_seen = 0;
    for (int c = 0; c < 7; c++) begin
      @(posedge clock); #1;
      start   = (c == 0);
      write   = 1'b0;
      addr    = (c == 0) ? 32'h0000_0055 : $urandom();
      reset   = !(c == 3 || c == 4);
      mem_ack = (c == 3 || c == 4);
      @(negedge clock);
      if (done) done_seen++;
      if (c == 2) check("rst_seq_in_req", int'(mem_req), 1);
      if (c == 4) begin
        check("rst_mid_outs", outs(), 0);
        check("rst_mid_mem_addr", int'(mem_addr), 0);
      end
      if (c == 6) check("rst_after_outs", outs(), 0);
    end
    check("rst_no_done", done_seen, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdr_mem_ctrl.md
# mdr_mem_ctrl

Memory-access sequencer for the MAR/MDR path of the processor datapath. On a one-cycle `start` from the control unit it loads the MAR, optionally loads the MDR from the bus for a store, and runs a req/ack handshake with the memory. For loads it captures memory read data into the MDR, then reports completion or a timeout. It is the only block that drives the MDR load and MDR source-select strobes during memory cycles.

## Interface
- `ADDR_W`, default 9: memory word-address width. `mem_addr` is the low `ADDR_W` bits of `addr`.
- `TIMEOUT`, default 15: maximum REQ cycles without `mem_ack` before abort. Must be at least 1.

Ports:
- `clock`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  begin access; sampled only in IDLE.
- `write`  in  1  1 = store, 0 = load; sampled with `start`.
- `addr`  in  32  effective address; sampled with `start`.
- `busy`  out  1  high in SETUP, REQ and DONE.
- `done`  out  1  one-cycle completion pulse (state DONE).
- `err`  out  1  timeout flag; held until next accepted `start`.
- `MARin`  out  1  MAR load strobe.
- `MDRin`  out  1  MDR load strobe.
- `MDR_in`  out  1  MDR source select: 1 = memory data, 0 = BusMuxOut.
- `mem_addr`  out  ADDR_W  latched word address.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  write enable, valid while `mem_req` = 1.
- `mem_ack`  in  1  memory acknowledge; for loads, read data is valid in the same cycle.

## Operation
- **IDLE**
  - `start` = 1 latches `mem_addr` ← `addr[ADDR_W-1:0]` and the write flag, clears `err`, and moves to SETUP.
  - `start` = 0 stays in IDLE.
- **SETUP** (exactly 1 cycle)
  - `MARin` = 1.
  - For a store: `MDRin` = 1 and `MDR_in` = 0, so the MDR loads BusMuxOut. The requester holds the store data on the bus during this cycle.
  - For a load: `MDRin` = 0.
  - Clears the wait counter and moves to REQ.
- **REQ**
  - `mem_req` = 1 and `mem_we` = write flag.
  - If `mem_ack` = 1 on a load: `MDRin` = 1 and `MDR_in` = 1 in the same cycle (Mealy), so the MDR captures memory data at the edge. Move to DONE.
  - If `mem_ack` = 1 on a store: move to DONE.
  - If `mem_ack` = 0 and the counter equals `TIMEOUT`-1: set `err` and move to DONE. The MDR is not loaded.
  - If `mem_ack` = 0 otherwise: increment the counter and stay in REQ.
- **DONE**
  - `done` = 1 for one cycle, then move to IDLE.
- Output decode: all strobes are decoded from state, plus `mem_ack` for the load capture. `MDR_in` = 0 in every state except a REQ load with `mem_ack` = 1.
- Counter width is `$clog2(TIMEOUT)`, minimum 1 bit. The counter never wraps.
- Boundary rules:
  - `start` outside IDLE is ignored; it is not queued.
  - `mem_ack` outside REQ is ignored.
  - If `mem_ack` arrives in the same cycle the timeout limit is reached, `mem_ack` wins: the access succeeds and `err` = 0.
  - `addr` bits above `ADDR_W` are ignored.
  - `mem_addr` is stable from SETUP through DONE.

## Timing
- Reset (`reset` = 0 at an edge):
  - state → IDLE, `mem_addr` = 0, `err` = 0, counter = 0.
  - All strobes are decoded 0: `busy`, `done`, `MARin`, `MDRin`, `MDR_in`, `mem_req`, `mem_we`.
  - Reset overrides all other inputs.
  - A reset mid-access aborts it with no `done` pulse, and `mem_req` drops after that edge.
- Latency, with `start` sampled at edge E0:
  - SETUP occupies the cycle after E0; REQ begins after E1.
  - With `mem_ack` in REQ cycle k (k = 1..`TIMEOUT`), DONE occupies the cycle after edge E(1+k).
  - Minimum start-to-`done` latency is 3 edges.
  - IDLE is re-entered one edge after DONE, so back-to-back accesses are spaced 4 cycles minimum.
- A timeout produces exactly `TIMEOUT` REQ cycles, then DONE with `err` = 1.

## Test plan
1. **Reset:** hold `reset` = 0 for 2 edges mid-REQ, with `mem_ack` = 1 asserted. Required: every output listed above is 0 after the first edge, and no `done` pulse occurs.
2. **Load, zero wait:** `start`, `write` = 0, `addr` = 0x0000_0123, `mem_ack` in the first REQ cycle. Required:
   - `MARin` high for 1 cycle and `mem_addr` = 0x123.
   - `mem_req` high for 1 cycle, with `MDRin` = `MDR_in` = 1 in that cycle.
   - `done` 3 edges after `start`; `err` = 0.
3. **Store, 3 wait states:** `write` = 1, `addr` = 0xFFFF_FE05, `mem_ack` in REQ cycle 4. Required:
   - SETUP shows `MARin` = `MDRin` = 1 and `MDR_in` = 0.
   - `mem_addr` = 0x005.
   - `mem_req` = `mem_we` = 1 for 4 cycles, `MDRin` = 0 throughout REQ.
   - `done` at edge 6.
4. **Timeout:** `TIMEOUT` = 15, load with no `mem_ack`. Required:
   - `mem_req` high for exactly 15 cycles.
   - `done` with `err` = 1; `MDRin` never asserted.
   - The next `start` clears `err` to 0.
5. **Races:** `mem_ack` in REQ cycle 15 with `TIMEOUT` = 15 → success with `err` = 0. A `start` pulse during REQ is ignored. A `mem_ack` during IDLE or SETUP produces no strobe and no state change.
